// File: rtl/mem_mgr_noc_pkg.sv
// Shared definitions for the memory-manager NoC decoder and encoder.
// Opcodes, decoder states and header field offsets.
package mem_mgr_noc_pkg;

    localparam logic [2:0] MPUT   = 3'd4;
    localparam logic [2:0] MGET   = 3'd5;
    localparam logic [2:0] MLOAD  = 3'd6;
    localparam logic [2:0] MSTORE = 3'd7;
    localparam logic [2:0] MACK   = 3'd2;
    localparam logic [2:0] MDATA  = 3'd3;

    localparam int HL_BIT    = 28;
    localparam int CODE_LSB  = 25;
    localparam int LEN_LSB   = 12;
    localparam int DST_Y_LSB = 3;
    localparam int DST_X_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SECOND_WORD,
        ST_THIRD_WORD,
        ST_WR_DATA,
        ST_RD_ISSUE,
        ST_WAIT_RESP,
        ST_IGNORE
    } state_t;

    function automatic logic is_wr_code(input logic [2:0] code);
        return (code == MPUT) || (code == MSTORE);
    endfunction

endpackage

// File: rtl/mem_mgr_req_reg.sv
// One-entry valid/ready output register for memory requests.
// Payload holds until the memory side accepts it.
module mem_mgr_req_reg #(
    parameter int ADDR_SZ = 32
) (
    input  logic               clk_ctrl,
    input  logic               clk_ctrl_rst,
    input  logic               ld_valid,
    input  logic               ld_we,
    input  logic [ADDR_SZ-1:0] ld_addr,
    input  logic [31:0]        ld_wdata,
    output logic               ld_ready,
    output logic               req_valid,
    output logic               req_we,
    output logic [ADDR_SZ-1:0] req_addr,
    output logic [31:0]        req_wdata,
    input  logic               req_ready
);

    assign ld_ready = !req_valid || req_ready;

    always_ff @(posedge clk_ctrl or posedge clk_ctrl_rst) begin
        if (clk_ctrl_rst) begin
            req_valid <= 1'b0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
        end else if (ld_valid && ld_ready) begin
            req_valid <= 1'b1;
            req_we    <= ld_we;
            req_addr  <= ld_addr;
            req_wdata <= ld_wdata;
        end else if (req_ready) begin
            req_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_mgr_noc_decoder.sv
// Ingress stage of the DRAM-tile memory manager: parses NoC packets
// and issues word read/write requests to the memory port.
module mem_mgr_noc_decoder
    import mem_mgr_noc_pkg::*;
#(
    parameter int XY_SZ        = 3,
    parameter int ADDR_SZ      = 32,
    parameter int MAX_LOG2_LEN = 8
) (
    input  logic               clk_ctrl,
    input  logic               clk_ctrl_rst,
    input  logic [2*XY_SZ-1:0] HsrcId,
    input  logic               stream_in_TVALID,
    input  logic [31:0]        stream_in_TDATA,
    input  logic [3:0]         stream_in_TKEEP,
    input  logic               stream_in_TLAST,
    output logic               stream_in_TREADY,
    output logic [31:0]        header1,
    output logic [31:0]        data1,
    output logic               cpu_req_valid,
    output logic               cpu_req_we,
    output logic [ADDR_SZ-1:0] cpu_req_addr,
    output logic [31:0]        cpu_req_wdata,
    input  logic               cpu_req_ready,
    input  logic               cpu_res_valid,
    input  logic               cpu_res_ready,
    output logic               busy,
    output logic               err_flag
);

    state_t state, state_nxt;

    logic               beat, req_fire, res_fire;
    logic               ld_valid, ld_we, ld_ready, ld_fire;
    logic [ADDR_SZ-1:0] ld_addr;
    logic [31:0]        ld_wdata;
    logic               err_set, wr_op, wr_last;
    logic [15:0]        ld_cnt, acc_cnt, res_cnt, exp_cnt;
    logic [ADDR_SZ-1:0] addr_reg;
    logic [2:0]         in_code;
    logic [3:0]         in_len;
    logic               in_hl, hdr_bad;
    logic [15:0]        in_n;
    logic               unused_keep;

    assign unused_keep = ^stream_in_TKEEP;

    assign in_code = stream_in_TDATA[CODE_LSB +: 3];
    assign in_len  = stream_in_TDATA[LEN_LSB +: 4];
    assign in_hl   = stream_in_TDATA[HL_BIT];
    assign in_n    = in_hl ? (16'd1 << in_len) : 16'd1;
    assign hdr_bad = ({stream_in_TDATA[DST_Y_LSB +: XY_SZ],
                       stream_in_TDATA[DST_X_LSB +: XY_SZ]} != HsrcId)
                   || !in_code[2]
                   || (in_hl && (in_len > 4'(MAX_LOG2_LEN)));

    assign beat     = stream_in_TVALID && stream_in_TREADY;
    assign req_fire = cpu_req_valid && cpu_req_ready;
    assign res_fire = cpu_res_valid && cpu_res_ready;
    assign ld_fire  = ld_valid && ld_ready;
    assign wr_op    = is_wr_code(header1[CODE_LSB +: 3]);
    assign wr_last  = (ld_cnt + 16'd1) == exp_cnt;
    assign ld_addr  = {addr_reg[ADDR_SZ-1:2], 2'b00};
    assign ld_wdata = ld_we ? stream_in_TDATA : 32'd0;
    assign busy     = state != ST_IDLE;

    always_ff @(posedge clk_ctrl or posedge clk_ctrl_rst) begin
        if (clk_ctrl_rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        unique case (state)
            ST_IDLE: if (beat) begin
                if (hdr_bad) begin
                    err_set   = 1'b1;
                    state_nxt = stream_in_TLAST ? ST_IDLE : ST_IGNORE;
                end else if (stream_in_TLAST) begin
                    err_set = 1'b1;
                end else begin
                    state_nxt = ST_SECOND_WORD;
                end
            end
            ST_SECOND_WORD: if (beat) begin
                if (stream_in_TLAST) begin
                    err_set   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = wr_op ? ST_WR_DATA : ST_THIRD_WORD;
                end
            end
            ST_THIRD_WORD: if (beat) begin
                if (stream_in_TLAST) begin
                    state_nxt = ST_RD_ISSUE;
                end else begin
                    err_set   = 1'b1;
                    state_nxt = ST_IGNORE;
                end
            end
            ST_WR_DATA: if (beat) begin
                if (stream_in_TLAST) begin
                    err_set   = !wr_last;
                    state_nxt = ST_WAIT_RESP;
                end else if (wr_last) begin
                    err_set   = 1'b1;
                    state_nxt = ST_IGNORE;
                end
            end
            ST_RD_ISSUE:
                if ((acc_cnt + 16'(req_fire)) == exp_cnt)
                    state_nxt = ST_WAIT_RESP;
            ST_WAIT_RESP:
                if ((res_cnt + 16'(res_fire)) >= exp_cnt)
                    state_nxt = ST_IDLE;
            ST_IGNORE:
                if (beat && stream_in_TLAST)
                    state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        stream_in_TREADY = 1'b0;
        ld_valid         = 1'b0;
        ld_we            = 1'b0;
        unique case (state)
            ST_IDLE, ST_SECOND_WORD, ST_THIRD_WORD, ST_IGNORE:
                stream_in_TREADY = 1'b1;
            ST_WR_DATA: begin
                stream_in_TREADY = ld_ready;
                ld_valid         = stream_in_TVALID;
                ld_we            = 1'b1;
            end
            ST_RD_ISSUE:
                ld_valid = ld_cnt != exp_cnt;
            default: ;
        endcase
        if (clk_ctrl_rst)
            stream_in_TREADY = 1'b0;
    end

    // Counters restart on every accepted header; responses count in any busy state.
    always_ff @(posedge clk_ctrl or posedge clk_ctrl_rst) begin
        if (clk_ctrl_rst) begin
            header1  <= '0;
            data1    <= '0;
            addr_reg <= '0;
            ld_cnt   <= '0;
            acc_cnt  <= '0;
            res_cnt  <= '0;
            exp_cnt  <= '0;
            err_flag <= 1'b0;
        end else begin
            err_flag <= err_flag | err_set;
            if (state == ST_IDLE) begin
                if (beat) begin
                    header1 <= stream_in_TDATA;
                    exp_cnt <= in_n;
                    ld_cnt  <= '0;
                    acc_cnt <= '0;
                    res_cnt <= '0;
                end
            end else begin
                if (req_fire)
                    acc_cnt <= acc_cnt + 16'd1;
                if (res_fire)
                    res_cnt <= res_cnt + 16'd1;
            end
            if (state == ST_SECOND_WORD && beat) begin
                data1    <= stream_in_TDATA;
                addr_reg <= ADDR_SZ'(stream_in_TDATA);
            end
            if (state == ST_THIRD_WORD && beat)
                addr_reg <= ADDR_SZ'(stream_in_TDATA);
            if (ld_fire) begin
                addr_reg <= addr_reg + ADDR_SZ'(4);
                ld_cnt   <= ld_cnt + 16'd1;
            end
            if (state == ST_WR_DATA && beat && stream_in_TLAST && !wr_last)
                exp_cnt <= ld_cnt + 16'd1;
        end
    end

    mem_mgr_req_reg #(.ADDR_SZ(ADDR_SZ)) u_req_reg (
        .clk_ctrl     (clk_ctrl),
        .clk_ctrl_rst (clk_ctrl_rst),
        .ld_valid     (ld_valid),
        .ld_we        (ld_we),
        .ld_addr      (ld_addr),
        .ld_wdata     (ld_wdata),
        .ld_ready     (ld_ready),
        .req_valid    (cpu_req_valid),
        .req_we       (cpu_req_we),
        .req_addr     (cpu_req_addr),
        .req_wdata    (cpu_req_wdata),
        .req_ready    (cpu_req_ready)
    );

endmodule

// File: tb/tb_mem_mgr_noc_decoder.sv
// Randomised bench for mem_mgr_noc_decoder against a packet-level
// model of expected memory requests and response bookkeeping.
module tb_mem_mgr_noc_decoder;
    import mem_mgr_noc_pkg::*;

    logic        clk_ctrl = 1'b0;
    logic        clk_ctrl_rst;
    logic [5:0]  HsrcId;
    logic        stream_in_TVALID;
    logic [31:0] stream_in_TDATA;
    logic [3:0]  stream_in_TKEEP;
    logic        stream_in_TLAST;
    logic        stream_in_TREADY;
    logic [31:0] header1, data1;
    logic        cpu_req_valid, cpu_req_we;
    logic [31:0] cpu_req_addr, cpu_req_wdata;
    logic        cpu_req_ready, cpu_res_valid, cpu_res_ready;
    logic        busy, err_flag;

    always #5 clk_ctrl = ~clk_ctrl;

    mem_mgr_noc_decoder #(
        .XY_SZ(3), .ADDR_SZ(32), .MAX_LOG2_LEN(8)
    ) dut (
        .clk_ctrl         (clk_ctrl),
        .clk_ctrl_rst     (clk_ctrl_rst),
        .HsrcId           (HsrcId),
        .stream_in_TVALID (stream_in_TVALID),
        .stream_in_TDATA  (stream_in_TDATA),
        .stream_in_TKEEP  (stream_in_TKEEP),
        .stream_in_TLAST  (stream_in_TLAST),
        .stream_in_TREADY (stream_in_TREADY),
        .header1          (header1),
        .data1            (data1),
        .cpu_req_valid    (cpu_req_valid),
        .cpu_req_we       (cpu_req_we),
        .cpu_req_addr     (cpu_req_addr),
        .cpu_req_wdata    (cpu_req_wdata),
        .cpu_req_ready    (cpu_req_ready),
        .cpu_res_valid    (cpu_res_valid),
        .cpu_res_ready    (cpu_res_ready),
        .busy             (busy),
        .err_flag         (err_flag)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    req_t        exp_q[$];
    req_t        e_m;
    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    int unsigned done_cyc = 0;
    int unsigned stall_at = 32'hFFFF_FFFF;
    int          stall_cnt = 0;
    int          pend = 0;
    int          res_exp = 0;
    int          res_seen = 0;
    int          n_fire = 0;
    logic [31:0] exp_hdr = 0;
    logic [31:0] exp_d1 = 0;
    bit          idle_chk = 0;
    bit          hold_v = 0;
    logic        h_we;
    logic [31:0] h_addr, h_wdata;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_hdr(input logic hl,
        input logic [2:0] code, input logic [3:0] l2,
        input logic [2:0] dy, input logic [2:0] dx);
        logic [5:0] src;
        src = 6'($urandom);
        return {3'b000, hl, code, 1'b0, src, 2'b00, l2, 6'd0, dy, dx};
    endfunction

    always @(posedge clk_ctrl) cyc <= cyc + 1;

    // Memory side: random backpressure, one response per accepted request.
    always @(posedge clk_ctrl) begin
        #1;
        if (cyc == stall_at) stall_cnt = 5;
        if (stall_cnt > 0) begin
            cpu_req_ready = 1'b0;
            stall_cnt--;
        end else begin
            cpu_req_ready = ($urandom_range(3) != 0);
        end
        cpu_res_valid = (pend > 0) && ($urandom_range(2) != 0);
        cpu_res_ready = ($urandom_range(3) != 0);
    end

    always @(negedge clk_ctrl) begin
        if (clk_ctrl_rst) begin
            hold_v   = 0;
            idle_chk = 0;
        end else begin
            if (hold_v) begin
                chk("req_hold_v", cpu_req_valid, 1);
                chk("req_hold_addr", cpu_req_addr, h_addr);
                chk("req_hold_pay", {cpu_req_we, cpu_req_wdata}, {h_we, h_wdata});
            end
            hold_v  = cpu_req_valid && !cpu_req_ready;
            h_we    = cpu_req_we;
            h_addr  = cpu_req_addr;
            h_wdata = cpu_req_wdata;
            if (cpu_req_valid && !cpu_req_ready && cpu_req_we)
                chk("wr_stall_tready", stream_in_TREADY, 0);
            if (cpu_req_valid && cpu_req_ready) begin
                n_fire++;
                pend++;
                if (exp_q.size() == 0) begin
                    chk("unexp_req", 1, 0);
                end else begin
                    e_m = exp_q.pop_front();
                    chk("req_we", cpu_req_we, e_m.we);
                    chk("req_addr", cpu_req_addr, e_m.addr);
                    if (e_m.we) chk("req_wdata", cpu_req_wdata, e_m.wdata);
                end
            end
            if (idle_chk && cyc == done_cyc + 1) begin
                chk("idle_after_res", busy, 0);
                idle_chk = 0;
            end
            if (cpu_res_valid && cpu_res_ready) begin
                if (pend > 0) pend--;
                if (res_seen < res_exp) begin
                    res_seen++;
                    chk("hdr_held", header1, exp_hdr);
                    chk("d1_held", data1, exp_d1);
                    if (res_seen == res_exp) begin
                        chk("busy_last_res", busy, 1);
                        done_cyc = cyc;
                        idle_chk = 1;
                    end
                end
            end
        end
    end

    // mode 0: no ready check, 1: header (ready once previous packet done), 2: must be ready
    task automatic send_beat(input logic [31:0] d, input logic last,
                             input int mode, output int unsigned acc);
        bit got;
        got = 0;
        acc = 0;
        stream_in_TDATA  = d;
        stream_in_TLAST  = last;
        stream_in_TVALID = 1'b1;
        for (int n = 0; n < 3000 && !got; n++) begin
            @(negedge clk_ctrl);
            #1;
            if (mode == 1) chk("hdr_tready", stream_in_TREADY, cyc > done_cyc);
            if (mode == 2) chk("beat_tready", stream_in_TREADY, 1);
            if (stream_in_TREADY) begin
                got = 1;
                acc = cyc;
            end
            @(posedge clk_ctrl);
            #1;
        end
        stream_in_TVALID = 1'b0;
        stream_in_TLAST  = 1'b0;
        if (!got) chk("beat_timeout", 0, 1);
    endtask

    task automatic gap();
        if ($urandom_range(3) == 0) begin
            @(posedge clk_ctrl);
            #1;
        end
    endtask

    task automatic send_pkt(input logic [2:0] code, input logic hl,
        input logic [3:0] l2, input logic [31:0] base,
        input logic [31:0] d1, input logic [31:0] wd0);
        int n;
        bit wr;
        logic [31:0] h, d;
        logic [31:0] dat[$];
        int unsigned ac;
        n  = hl ? (1 << l2) : 1;
        wr = (code == MPUT) || (code == MSTORE);
        h  = mk_hdr(hl, code, l2, 3'd2, 3'd3);
        for (int i = 0; i < n; i++) begin
            d = (i == 0) ? wd0 : $urandom;
            if (wr) dat.push_back(d);
            exp_q.push_back('{we: wr, addr: base + 32'(4 * i),
                              wdata: wr ? d : 32'd0});
        end
        gap();
        send_beat(h, 0, 1, ac);
        done_cyc = 32'hFFFF_FFFF;
        res_exp  = n;
        res_seen = 0;
        exp_hdr  = h;
        if (wr) begin
            exp_d1 = base;
            gap();
            send_beat(base, 0, 2, ac);
            for (int i = 0; i < n; i++) begin
                gap();
                send_beat(dat[i], i == n - 1, 0, ac);
            end
        end else begin
            exp_d1 = d1;
            gap();
            send_beat(d1, 0, 2, ac);
            gap();
            send_beat(base, 1, 2, ac);
        end
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 20000; k++) begin
            if (cyc > done_cyc && exp_q.size() == 0) break;
            @(posedge clk_ctrl);
            #1;
        end
        chk("idle_timeout", k < 20000, 1);
        @(negedge clk_ctrl);
        #1;
        chk("busy_idle", busy, 0);
        chk("err_clean", err_flag, 0);
        @(posedge clk_ctrl);
        #1;
    endtask

    task automatic send_bad(input logic [31:0] h);
        int n0;
        int unsigned ac;
        n0 = n_fire;
        send_beat(h, 0, 1, ac);
        send_beat(32'h1234_0000, 0, 2, ac);
        send_beat(32'h0000_5678, 1, 2, ac);
        done_cyc = ac;
        @(negedge clk_ctrl);
        #1;
        chk("bad_err", err_flag, 1);
        chk("bad_busy", busy, 0);
        chk("bad_noreq", n_fire - n0, 0);
        @(posedge clk_ctrl);
        #1;
    endtask

    task automatic do_reset();
        clk_ctrl_rst = 1'b1;
        #1;
        chk("rst_req_valid", cpu_req_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_flag, 0);
        chk("rst_hdr", header1, 0);
        chk("rst_d1", data1, 0);
        chk("rst_tready", stream_in_TREADY, 0);
        exp_q.delete();
        pend      = 0;
        res_exp   = 0;
        res_seen  = 0;
        done_cyc  = 0;
        stall_cnt = 0;
        repeat (2) @(posedge clk_ctrl);
        #1;
        clk_ctrl_rst = 1'b0;
        @(negedge clk_ctrl);
        #1;
        chk("post_rst_tready", stream_in_TREADY, 1);
        chk("post_rst_busy", busy, 0);
        @(posedge clk_ctrl);
        #1;
    endtask

    initial begin
        logic [31:0] rb;
        logic [2:0]  rc;
        int unsigned ac;
        clk_ctrl_rst     = 1'b1;
        HsrcId           = 6'b010_011;
        stream_in_TVALID = 1'b0;
        stream_in_TDATA  = '0;
        stream_in_TKEEP  = 4'hF;
        stream_in_TLAST  = 1'b0;
        cpu_req_ready    = 1'b0;
        cpu_res_valid    = 1'b0;
        cpu_res_ready    = 1'b0;
        repeat (2) @(posedge clk_ctrl);
        #1;
        do_reset();

        send_pkt(MSTORE, 0, 0, 32'h100, 0, 32'hDEAD_BEEF);
        wait_idle();
        stall_at = cyc + 6;
        send_pkt(MPUT, 1, 2, 32'h40, 0, $urandom);
        wait_idle();
        send_pkt(MGET, 1, 3, 32'h200, 32'h55, 0);
        wait_idle();
        send_pkt(MLOAD, 0, 0, 32'h300, 32'h77, 0);
        send_pkt(MLOAD, 0, 0, 32'h304, 32'h78, 0);
        wait_idle();
        send_pkt(MPUT, 1, 2, 32'hFFFF_FFF8, 0, $urandom);
        send_pkt(MGET, 1, 8, 32'h1000, 32'h9, 0);
        wait_idle();

        for (int i = 0; i < 30; i++) begin
            rb = $urandom;
            rb[1:0] = 2'b00;
            rc = 3'(4 + $urandom_range(3));
            send_pkt(rc, 1'($urandom_range(1)), 4'($urandom_range(4)),
                     rb, $urandom, $urandom);
            if ($urandom_range(1) == 0) wait_idle();
        end
        wait_idle();

        send_bad(mk_hdr(0, MSTORE, 0, 3'd1, 3'd3));
        do_reset();
        send_bad(mk_hdr(0, MACK, 0, 3'd2, 3'd3));
        do_reset();
        send_bad(mk_hdr(1, MGET, 9, 3'd2, 3'd3));
        do_reset();

        // abandon a long write partway through
        res_exp  = 8;
        res_seen = 0;
        exp_q.push_back('{we: 1, addr: 32'h500, wdata: 32'hA0});
        exp_q.push_back('{we: 1, addr: 32'h504, wdata: 32'hA1});
        send_beat(mk_hdr(1, MPUT, 3, 3'd2, 3'd3), 0, 1, ac);
        done_cyc = 32'hFFFF_FFFF;
        send_beat(32'h500, 0, 2, ac);
        send_beat(32'hA0, 0, 0, ac);
        send_beat(32'hA1, 0, 0, ac);
        do_reset();

        send_pkt(MSTORE, 0, 0, 32'h600, 0, 32'h1357_9BDF);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
